// File: rtl/vga_bus_pkg.sv
// Shared constants for the VGA timing/pixel bus pipeline.
// Default field widths, reset levels for the bus fields, and the depth limit.
package vga_bus_pkg;

    localparam int HCOUNT_W_DEF = 11;
    localparam int VCOUNT_W_DEF = 11;
    localparam int RGB_W_DEF    = 12;

    localparam logic BLNK_RST = 1'b1;
    localparam logic SYNC_RST = 1'b0;

    localparam int MAX_DELAY = 16;

    // Bits needed to count from 0 up to d inclusive; 1 bit when d == 1.
    function automatic int fill_width(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/vga_bus_reg.sv
// One register stage of the VGA bus. When MASK_RGB is set, rgb is loaded as
// black whenever the incoming hblnk or vblnk is high.
module vga_bus_reg
    import vga_bus_pkg::*;
#(
    parameter int HCOUNT_W = HCOUNT_W_DEF,
    parameter int VCOUNT_W = VCOUNT_W_DEF,
    parameter int RGB_W    = RGB_W_DEF,
    parameter bit MASK_RGB = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VCOUNT_W-1:0] in_vcount,
    input  logic                in_vsync,
    input  logic                in_vblnk,
    input  logic [HCOUNT_W-1:0] in_hcount,
    input  logic                in_hsync,
    input  logic                in_hblnk,
    input  logic [RGB_W-1:0]    in_rgb,
    output logic [VCOUNT_W-1:0] out_vcount,
    output logic                out_vsync,
    output logic                out_vblnk,
    output logic [HCOUNT_W-1:0] out_hcount,
    output logic                out_hsync,
    output logic                out_hblnk,
    output logic [RGB_W-1:0]    out_rgb
);

    logic blank_in;

    assign blank_in = in_hblnk | in_vblnk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vcount <= '0;
            out_vsync  <= SYNC_RST;
            out_vblnk  <= BLNK_RST;
            out_hcount <= '0;
            out_hsync  <= SYNC_RST;
            out_hblnk  <= BLNK_RST;
            out_rgb    <= '0;
        end else begin
            out_vcount <= in_vcount;
            out_vsync  <= in_vsync;
            out_vblnk  <= in_vblnk;
            out_hcount <= in_hcount;
            out_hsync  <= in_hsync;
            out_hblnk  <= in_hblnk;
            out_rgb    <= (MASK_RGB && blank_in) ? '0 : in_rgb;
        end
    end

endmodule

// File: rtl/vga_bus_delay.sv
// Fixed-depth pipeline for the VGA bus, used to realign timing with pixel data
// from multi-cycle drawing stages. Free-running: no valid/ready, no stall.
module vga_bus_delay
    import vga_bus_pkg::*;
#(
    parameter int DELAY     = 2,
    parameter int HCOUNT_W  = HCOUNT_W_DEF,
    parameter int VCOUNT_W  = VCOUNT_W_DEF,
    parameter int RGB_W     = RGB_W_DEF,
    parameter int BLANK_RGB = 1,
    parameter int FRAME_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VCOUNT_W-1:0] in_vcount,
    input  logic                in_vsync,
    input  logic                in_vblnk,
    input  logic [HCOUNT_W-1:0] in_hcount,
    input  logic                in_hsync,
    input  logic                in_hblnk,
    input  logic [RGB_W-1:0]    in_rgb,
    output logic [VCOUNT_W-1:0] out_vcount,
    output logic                out_vsync,
    output logic                out_vblnk,
    output logic [HCOUNT_W-1:0] out_hcount,
    output logic                out_hsync,
    output logic                out_hblnk,
    output logic [RGB_W-1:0]    out_rgb,
    output logic                out_valid,
    output logic                frame_start,
    output logic [FRAME_W-1:0]  frame_cnt
);

    localparam int FILL_W = fill_width(DELAY);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DELAY);

    if (DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_delay
        $error("vga_bus_delay: DELAY must be within 1..16");
    end

    // Index 0 is the input bus; index k+1 is the output of stage k.
    logic [VCOUNT_W-1:0] vc [0:DELAY];
    logic                vs [0:DELAY];
    logic                vb [0:DELAY];
    logic [HCOUNT_W-1:0] hc [0:DELAY];
    logic                hs [0:DELAY];
    logic                hb [0:DELAY];
    logic [RGB_W-1:0]    px [0:DELAY];

    assign vc[0] = in_vcount;
    assign vs[0] = in_vsync;
    assign vb[0] = in_vblnk;
    assign hc[0] = in_hcount;
    assign hs[0] = in_hsync;
    assign hb[0] = in_hblnk;
    assign px[0] = in_rgb;

    for (genvar k = 0; k < DELAY; k++) begin : g_stage
        vga_bus_reg #(
            .HCOUNT_W (HCOUNT_W),
            .VCOUNT_W (VCOUNT_W),
            .RGB_W    (RGB_W),
            .MASK_RGB ((k == DELAY - 1) && (BLANK_RGB != 0))
        ) u_reg (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_vcount  (vc[k]),
            .in_vsync   (vs[k]),
            .in_vblnk   (vb[k]),
            .in_hcount  (hc[k]),
            .in_hsync   (hs[k]),
            .in_hblnk   (hb[k]),
            .in_rgb     (px[k]),
            .out_vcount (vc[k+1]),
            .out_vsync  (vs[k+1]),
            .out_vblnk  (vb[k+1]),
            .out_hcount (hc[k+1]),
            .out_hsync  (hs[k+1]),
            .out_hblnk  (hb[k+1]),
            .out_rgb    (px[k+1])
        );
    end

    assign out_vcount = vc[DELAY];
    assign out_vsync  = vs[DELAY];
    assign out_vblnk  = vb[DELAY];
    assign out_hcount = hc[DELAY];
    assign out_hsync  = hs[DELAY];
    assign out_hblnk  = hb[DELAY];
    assign out_rgb    = px[DELAY];

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_nxt;
    logic              valid_nxt;
    logic              start_nxt;

    // Flags are computed from what the last stage is about to load, so they
    // line up with the out_* values they describe.
    always_comb begin
        fill_nxt  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        valid_nxt = (fill_nxt == FILL_FULL);
        start_nxt = valid_nxt && (vc[DELAY-1] == '0) && (hc[DELAY-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            fill_q      <= fill_nxt;
            out_valid   <= valid_nxt;
            frame_start <= start_nxt;
            if (start_nxt) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

endmodule
